// File: rtl/trigger_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sniffer_pkg
// Shared definitions for the bus sniffer trigger sequencer: controller state
// encoding, default widths and the occurrence-count helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sniffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int DEF_NUM_MATCH  = 4;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_STG_WIDTH  = 2;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_TO_WIDTH   = 32;

  // A programmed count of zero means "one occurrence"; the caller truncates
  // the result back to its own counter width.
  function automatic logic [63:0] eff_count(input logic [63:0] cnt);
    if (cnt == 64'd0) begin
      return 64'd1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// -----------------------------------------------------------------------------
// trigger_sequencer_if
// Control/status bundle between the sniffer front end and the trigger
// sequencer.
//   arm, abort   : run control from the front end
//   match        : registered comparator match pulses
//   comp_enable  : comparator enable
//   trigger      : one-cycle pulse to the capture logic
//   busy, done, timed_out, cur_stage : sequencer status
// master = front end / bench side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface trigger_sequencer_if #(
  parameter int NUM_MATCH = 4,
  parameter int STG_WIDTH = 2
);
  import sniffer_pkg::*;

  logic                 arm;
  logic                 abort;
  logic [NUM_MATCH-1:0] match;
  logic                 comp_enable;
  logic                 trigger;
  logic                 busy;
  logic                 done;
  logic                 timed_out;
  logic [STG_WIDTH-1:0] cur_stage;

  modport master (
    output arm, abort, match,
    input  comp_enable, trigger, busy, done, timed_out, cur_stage
  );

  modport slave (
    input  arm, abort, match,
    output comp_enable, trigger, busy, done, timed_out, cur_stage
  );

endinterface

// File: rtl/trigger_sequencer_stage_counter.sv
// -----------------------------------------------------------------------------
// stage_counter
// Occurrence counter for the active trigger stage.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous clear (priority over inc)
//   inc        : count one occurrence this cycle
//   limit      : effective occurrence count for the stage (>= 1)
//   term       : this cycle's occurrence completes the stage
// -----------------------------------------------------------------------------
module stage_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 term
);

  logic [CNT_WIDTH-1:0] occ_r;
  logic [CNT_WIDTH:0]   occ_inc_s;

  // Terminal-count compare done one bit wider so a saturated count never aliases.
  always_comb begin
    occ_inc_s = {1'b0, occ_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
    term      = inc && (occ_inc_s == {1'b0, limit});
  end

  // Occurrence register: clear wins, saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_r <= {CNT_WIDTH{1'b0}};
    end else if (clear) begin
      occ_r <= {CNT_WIDTH{1'b0}};
    end else if (inc && (occ_r != {CNT_WIDTH{1'b1}})) begin
      occ_r <= occ_inc_s[CNT_WIDTH-1:0];
    end else begin
      occ_r <= occ_r;
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
// Multi-stage trigger for the bus sniffer comparator bank. While armed the
// comparators are enabled and match pulses of the selected input are counted
// per stage; completing the last stage emits a one-cycle trigger. An optional
// cycle limit aborts runs that never complete.
//   clk, reset      : clock, asynchronous active-low reset
//   cfg_last_stage  : index of final stage (clamped to NUM_STAGES-1)
//   cfg_sel         : match input per stage, stage i at [i*SEL_WIDTH +: SEL_WIDTH]
//   cfg_count       : occurrences per stage, 0 treated as 1
//   cfg_timeout     : run cycle limit, 0 disables
//   bus             : arm/abort/match in, comp_enable/trigger/status out
// -----------------------------------------------------------------------------
module trigger_sequencer
  import sniffer_pkg::*;
#(
  parameter int NUM_MATCH  = DEF_NUM_MATCH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STG_WIDTH  = DEF_STG_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TO_WIDTH   = DEF_TO_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [STG_WIDTH-1:0]            cfg_last_stage,
  input  logic [NUM_STAGES*SEL_WIDTH-1:0] cfg_sel,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] cfg_count,
  input  logic [TO_WIDTH-1:0]             cfg_timeout,
  trigger_sequencer_if.slave              bus
);

  localparam int MATCH_PAD = 2 ** SEL_WIDTH;

  seq_state_t           state_r;
  logic                 comp_en_r;
  logic                 trigger_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 timed_out_r;
  logic [STG_WIDTH-1:0] stage_r;
  logic [TO_WIDTH-1:0]  tcnt_r;

  // Configuration snapshot taken at arm time.
  logic [SEL_WIDTH-1:0] shadow_sel_r [NUM_STAGES];
  logic [CNT_WIDTH-1:0] shadow_cnt_r [NUM_STAGES];
  logic [STG_WIDTH-1:0] shadow_last_r;
  logic [TO_WIDTH-1:0]  shadow_to_r;

  logic [MATCH_PAD-1:0] match_pad_s;
  logic [SEL_WIDTH-1:0] sel_idx_s;
  logic                 sel_hit_s;
  logic [CNT_WIDTH-1:0] limit_s;
  logic                 stage_done_s;
  logic                 is_last_s;
  logic                 timeout_hit_s;
  logic                 cnt_clear_s;
  logic [STG_WIDTH-1:0] last_clamped_s;

  // Active-stage match selection, limits and timeout detection.
  always_comb begin
    match_pad_s = MATCH_PAD'(bus.match);
    sel_idx_s   = shadow_sel_r[stage_r];
    // Selector values past the last comparator read as a constant 0.
    if ((state_r == ST_RUN) && (32'(sel_idx_s) < NUM_MATCH)) begin
      sel_hit_s = match_pad_s[sel_idx_s];
    end else begin
      sel_hit_s = 1'b0;
    end
    limit_s       = CNT_WIDTH'(eff_count(64'(shadow_cnt_r[stage_r])));
    is_last_s     = (stage_r == shadow_last_r);
    timeout_hit_s = (shadow_to_r != {TO_WIDTH{1'b0}}) &&
                    ((tcnt_r + TO_WIDTH'(1)) == shadow_to_r);
    // Advancing also clears, so the completing match is never carried forward.
    cnt_clear_s   = (state_r != ST_RUN) || bus.abort || stage_done_s;
    if (32'(cfg_last_stage) >= NUM_STAGES) begin
      last_clamped_s = STG_WIDTH'(NUM_STAGES - 1);
    end else begin
      last_clamped_s = cfg_last_stage;
    end
  end

  stage_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stage_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear_s),
    .inc   (sel_hit_s),
    .limit (limit_s),
    .term  (stage_done_s)
  );

  // Sequencer FSM with registered outputs; abort overrides every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      comp_en_r     <= 1'b0;
      trigger_r     <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timed_out_r   <= 1'b0;
      stage_r       <= {STG_WIDTH{1'b0}};
      tcnt_r        <= {TO_WIDTH{1'b0}};
      shadow_last_r <= {STG_WIDTH{1'b0}};
      shadow_to_r   <= {TO_WIDTH{1'b0}};
      for (int i = 0; i < NUM_STAGES; i++) begin
        shadow_sel_r[i] <= {SEL_WIDTH{1'b0}};
        shadow_cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (bus.abort) begin
      state_r     <= ST_IDLE;
      comp_en_r   <= 1'b0;
      trigger_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      timed_out_r <= 1'b0;
      stage_r     <= {STG_WIDTH{1'b0}};
      tcnt_r      <= {TO_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.arm) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              shadow_sel_r[i] <= cfg_sel[i*SEL_WIDTH +: SEL_WIDTH];
              shadow_cnt_r[i] <= cfg_count[i*CNT_WIDTH +: CNT_WIDTH];
            end
            shadow_last_r <= last_clamped_s;
            shadow_to_r   <= cfg_timeout;
            stage_r       <= {STG_WIDTH{1'b0}};
            tcnt_r        <= {TO_WIDTH{1'b0}};
            comp_en_r     <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          tcnt_r <= tcnt_r + TO_WIDTH'(1);
          // Stage completion takes precedence over a coincident timeout.
          if (stage_done_s) begin
            if (is_last_s) begin
              trigger_r <= 1'b1;
              comp_en_r <= 1'b0;
              busy_r    <= 1'b0;
              state_r   <= ST_FIRE;
            end else begin
              stage_r <= stage_r + STG_WIDTH'(1);
            end
          end else if (timeout_hit_s) begin
            comp_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            timed_out_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIRE: begin
          trigger_r <= 1'b0;
          done_r    <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.arm) begin
            done_r      <= 1'b0;
            timed_out_r <= 1'b0;
            stage_r     <= {STG_WIDTH{1'b0}};
            tcnt_r      <= {TO_WIDTH{1'b0}};
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          comp_en_r   <= 1'b0;
          trigger_r   <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          timed_out_r <= 1'b0;
          stage_r     <= {STG_WIDTH{1'b0}};
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.comp_enable = comp_en_r;
  assign bus.trigger     = trigger_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timed_out   = timed_out_r;
  assign bus.cur_stage   = stage_r;

endmodule
